// File: rtl/bch_syndrome_calc.sv
// bch_syndrome_calc: serial syndrome generator for BCH(15,5,t=3) over GF(2^4),
// primitive polynomial x^4+x+1. Streams S1..S6 as six consecutive beats.
// Optional build macro BCH_SYND_POLY_OUT_EN: emit raw polynomial-basis vectors
// (zero = 4'd0) instead of exponent form (zero = 4'd15). Timing is identical.

// One syndrome accumulator: acc <= acc*alpha^J ^ in_bit (Horner, r14 first).
module bch_synd_lane #(
  parameter int J = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       shift,
  input  logic       in_bit,
  output logic [3:0] acc
);
  // Constant-power multiply: J unrolled alpha-shifts collapse to an XOR network.
  function automatic logic [3:0] mul_alpha_j(input logic [3:0] v);
    logic [3:0] r;
    r = v;
    for (int k = 0; k < J; k++) r = {r[2:0], 1'b0} ^ {2'b00, r[3], r[3]};
    return r;
  endfunction

  // First beat of a frame loads the bit directly (cleared accumulator times
  // anything is zero); later valid beats run one Horner step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     acc <= '0;
    else if (start) acc <= {3'b000, in_bit};
    else if (shift) acc <= mul_alpha_j(acc) ^ {3'b000, in_bit};
  end
endmodule

module bch_syndrome_calc #(
  parameter int N    = 15,
  parameter int NSYN = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       out_valid,
  output logic [3:0] out_syndrome
);
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

  state_t                      state, state_nxt;
  logic [3:0]                  cnt;
  logic [2:0]                  beat;
  logic [NSYN-1:0][3:0]        acc;
  logic                        start, shift;

  // Accept bits only in IDLE (frame start) or ACC; in_valid during OUT is ignored.
  assign start = (state == S_IDLE) && in_valid;
  assign shift = (state == S_ACC)  && in_valid;

  for (genvar g = 0; g < NSYN; g++) begin : g_lane
    bch_synd_lane #(.J(g + 1)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .shift  (shift),
      .in_bit (in_bit),
      .acc    (acc[g])
    );
  end

`ifndef BCH_SYND_POLY_OUT_EN
  // Vector -> exponent of alpha; zero element maps to 15.
  function automatic logic [3:0] fmt(input logic [3:0] v);
    case (v)
      4'd1:  return 4'd0;
      4'd2:  return 4'd1;
      4'd3:  return 4'd4;
      4'd4:  return 4'd2;
      4'd5:  return 4'd8;
      4'd6:  return 4'd5;
      4'd7:  return 4'd10;
      4'd8:  return 4'd3;
      4'd9:  return 4'd14;
      4'd10: return 4'd9;
      4'd11: return 4'd7;
      4'd12: return 4'd6;
      4'd13: return 4'd13;
      4'd14: return 4'd11;
      4'd15: return 4'd12;
      default: return 4'd15;
    endcase
  endfunction
`else
  // Raw polynomial-basis vector {a3,a2,a1,a0}; zero element is 4'd0.
  function automatic logic [3:0] fmt(input logic [3:0] v);
    return v;
  endfunction
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: 15 valid beats collect a frame, then 6 output beats.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_ACC;
      S_ACC:   if (in_valid && cnt == 4'(N - 1)) state_nxt = S_OUT;
      S_OUT:   if (beat == 3'(NSYN - 1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bit counter (valid beats only, holds across gaps) and output beat index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      beat <= '0;
    end else begin
      if (start)      cnt <= 4'd1;
      else if (shift) cnt <= (cnt == 4'(N - 1)) ? 4'd0 : cnt + 4'd1;
      beat <= (state == S_OUT) ? beat + 3'd1 : 3'd0;
    end
  end

  // Registered output: one syndrome per OUT cycle, zero while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_syndrome <= '0;
    end else if (state == S_OUT) begin
      out_valid    <= 1'b1;
      out_syndrome <= fmt(acc[beat]);
    end else begin
      out_valid    <= 1'b0;
      out_syndrome <= '0;
    end
  end
endmodule

// File: tb/tb_bch_syndrome_calc.sv
// Bench for bch_syndrome_calc: table of spec vectors, hand-written reset and
// protocol-violation sequences, then random frames against a GF(16) model.
module tb_bch_syndrome_calc;
  typedef logic [5:0][3:0] syn_t;
  typedef struct {
    string       name;
    logic [14:0] w;
    int          gap_pos;
    int          gap_len;
    syn_t        exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       out_valid;
  logic [3:0] out_syndrome;

  int n_chk  = 0;
  int n_pass = 0;
  int pw[15];

  bch_syndrome_calc dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_bit       (in_bit),
    .out_valid    (out_valid),
    .out_syndrome (out_syndrome)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Exponent (15 = zero) -> expected output encoding for this build.
  function automatic logic [3:0] form(input int e);
`ifdef BCH_SYND_POLY_OUT_EN
    return (e == 15) ? 4'd0 : 4'(pw[e]);
`else
    return 4'(e);
`endif
  endfunction

  function automatic syn_t mk(input int a, b, c, d, e, f);
    syn_t s;
    s[0] = form(a); s[1] = form(b); s[2] = form(c);
    s[3] = form(d); s[4] = form(e); s[5] = form(f);
    return s;
  endfunction

  // Reference: S_j = sum over set bits r_i of alpha^(i*j mod 15).
  function automatic syn_t model(input logic [14:0] w);
    syn_t s;
    for (int j = 1; j <= 6; j++) begin
      int v = 0;
      int e = 15;
      for (int i = 0; i < 15; i++) if (w[i]) v = v ^ pw[(i * j) % 15];
      for (int k = 0; k < 15; k++) if (pw[k] == v) e = k;
      s[j-1] = form(e);
    end
    return s;
  endfunction

  task automatic run_frame(input string nm, input logic [14:0] w, input int gap_pos,
                           input int gap_len, input bit viol, input syn_t e);
    for (int i = 0; i < 15; i++) begin
      if (i == gap_pos) begin
        in_valid = 1'b0;
        repeat (gap_len) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_bit   = w[14-i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
    chk({nm, " early vld"}, out_valid, 0);
    for (int c = 0; c < 6; c++) begin
      if (viol) begin in_valid = 1'b1; in_bit = 1'($urandom_range(0, 1)); end
      @(posedge clk); #1;
      chk($sformatf("%s S%0d vld", nm, c + 1), out_valid, 1);
      chk($sformatf("%s S%0d", nm, c + 1), out_syndrome, e[c]);
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
    @(posedge clk); #1;
    chk({nm, " drop vld"}, out_valid, 0);
    chk({nm, " drop syn"}, out_syndrome, 0);
  endtask

  initial begin
    vec_t tab[6];
    int v;
    v = 1;
    for (int k = 0; k < 15; k++) begin
      pw[k] = v;
      v = v << 1;
      if (v & 16) v = v ^ 19;
    end

    tab[0] = '{"zero",  15'h0000, -1, 0, mk(15, 15, 15, 15, 15, 15)};
    tab[1] = '{"r0",    15'h0001, -1, 0, mk(0, 0, 0, 0, 0, 0)};
    tab[2] = '{"r1",    15'h0002, -1, 0, mk(1, 2, 3, 4, 5, 6)};
    tab[3] = '{"r14",   15'h4000, -1, 0, mk(14, 13, 12, 11, 10, 9)};
    tab[4] = '{"r0r1",  15'h0003, -1, 0, mk(4, 8, 14, 1, 10, 13)};
    tab[5] = '{"r0r1g", 15'h0003,  8, 3, mk(4, 8, 14, 1, 10, 13)};

    // Reset state.
    #12;
    chk("rst vld", out_valid, 0);
    chk("rst syn", out_syndrome, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Spec vectors, back-to-back (next frame starts as out_valid falls).
    for (int t = 0; t < 6; t++)
      run_frame(tab[t].name, tab[t].w, tab[t].gap_pos, tab[t].gap_len, 1'b0, tab[t].exp);

    // in_valid during output is ignored; the following frame is unaffected.
    run_frame("viol", 15'h0003, -1, 0, 1'b1, mk(4, 8, 14, 1, 10, 13));
    run_frame("after viol", 15'h0002, -1, 0, 1'b0, mk(1, 2, 3, 4, 5, 6));

    // Reset after 8 bits discards the partial frame.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_bit = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midframe rst vld", out_valid, 0);
    chk("midframe rst syn", out_syndrome, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_frame("post rst r1", 15'h0002, -1, 0, 1'b0, mk(1, 2, 3, 4, 5, 6));

    // Reset in the middle of the output burst.
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1; in_bit = (i == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_bit = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("midout vld", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midout rst vld", out_valid, 0);
    chk("midout rst syn", out_syndrome, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_frame("post rst zero", 15'h0000, -1, 0, 1'b0, mk(15, 15, 15, 15, 15, 15));

    // Random frames with optional mid-frame gaps.
    for (int t = 0; t < 12; t++) begin
      logic [14:0] w;
      int gp, gl;
      w  = 15'($urandom);
      gp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 14)) : -1;
      gl = int'($urandom_range(1, 4));
      run_frame($sformatf("rand%0d", t), w, gp, gl, 1'b0, model(w));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bch_syndrome_calc.md
Name: bch_syndrome_calc

Overview:
Upstream stage of the BCH(15,5,t=3) decoder over GF(2^4), primitive polynomial x^4+x+1. It accepts a 15-bit received word serially and evaluates S_j = r(alpha^j) for j=1..6. It streams the six syndromes to the error-locator stage in exactly that stage's input format: 6 consecutive valid beats, 4-bit exponent form, 4'd15 = zero element.

Parameters:
N, 15, codeword length in bits (fixed for GF(2^4); not intended to be overridden)
NSYN, 6, number of syndromes produced (2t, t=3)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  qualifies in_bit; 15 qualified beats form one frame
in_bit  input  1  received bit; r14 first, r0 last
out_valid  output  1  high for exactly 6 consecutive cycles per frame
out_syndrome  output  4  S1..S6 in order; exponent k means alpha^k, 15 means zero

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_syndrome=0, all six accumulators=0, bit counter=0, FSM=IDLE. Reset mid-frame or mid-output discards all work; the next frame starts from r14.
- FSM states:
  - IDLE: wait for in_valid.
  - ACC: accumulate bits.
  - OUT: emit syndromes.
- IDLE->ACC on the first in_valid=1 cycle; that bit is accumulated in the same cycle.
- Accumulation uses Horner form in polynomial basis, per valid beat, all j in parallel: acc_j <= acc_j*alpha^j XOR {3'b0,in_bit}.
  - Each *alpha^j is a fixed XOR network; no general multiplier.
  - Accumulators clear to 0 when a new frame begins.
- Gaps inside a frame: in_valid=0 while in ACC holds the accumulators and the counter (pause). Bits are counted only on valid beats.
- ACC->OUT on the cycle the 15th valid bit is registered (counter==14 && in_valid).
- OUT behaviour:
  - out_valid rises on the next rising edge, i.e. 1 cycle after the last input beat.
  - out_syndrome = log(acc_1) .. log(acc_6) on beats 0..5.
  - log() is a 16-entry LUT mapping vector to exponent, with 0 -> 15.
- OUT->IDLE after beat 5. out_valid drops the following cycle, and the next frame may start in that same cycle.
- While out_valid=0, out_syndrome is driven to 0 (the downstream bench checks this).
- in_valid during OUT is a protocol violation. The block ignores it: no accumulation, no state change, and output is unaffected.
- Outputs are registered; no combinational path from inputs to outputs.
- Latency: first syndrome 1 cycle after the 15th valid bit; 6 output cycles; minimum frame period 15+6=21 cycles.

Optional Feature:
Macro BCH_SYND_POLY_OUT_EN.
- Defined: out_syndrome carries the raw polynomial-basis vector {a3,a2,a1,a0} and the log LUT is removed. The zero element is then 4'd0; timing is identical.
- Undefined (default, required by the current locator stage): exponent form with 15 = zero.

Test Plan:
- All-zero word (15 zeros, contiguous) -> out_valid 6 cycles, out_syndrome 15,15,15,15,15,15; first beat 1 cycle after last bit.
- Single error at r0 (bits 000000000000001) -> 0,0,0,0,0,0.
- Single error at r1 -> 1,2,3,4,5,6. Single error at r14 (first bit=1, rest 0) -> 14,13,12,11,10,9.
- Errors at r0 and r1 -> 4,8,14,1,10,13. Repeat with in_valid deasserted for 3 cycles after bit 7 -> identical result.
- Back-to-back frames:
  - Send frame B starting the cycle after out_valid falls -> correct B syndromes.
  - Assert in_valid during OUT -> ignored, current outputs unchanged.
  - Reset after 8 bits, then send r1-error word -> 1,2,3,4,5,6.
- With BCH_SYND_POLY_OUT_EN: errors at r0, r1 -> vectors 3,5,9,2,7,13; all-zero word -> 0 x6.
